des_hit_collector: RTL and testbench

- Downstream of the message counter and the pipelined DES core in the key/message search datapath.
- Delays each counter message so it lines up with the DES ciphertext it produced, then compares that ciphertext against a masked target.
- Buffers matching messages in a first-word-fall-through (FWFT) FIFO for the host.
- Drives back-pressure (pause) to the counter and reports region completion once the DES pipeline has drained.

---
 rtl/des_hit_collector_pkg.sv | 20 ++
 rtl/des_hit_collector_if.sv | 25 ++
 rtl/des_hit_collector_fifo.sv | 51 +++++
 rtl/des_hit_collector.sv | 140 ++++++++++++++
 tb/tb_des_hit_collector.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/des_hit_collector_pkg.sv
// Shared types and constants for the DES key/message search datapath.
package des_search_pkg;

    localparam int MSG_W       = 64;
    localparam int DEF_LATENCY = 16;
    localparam int DEF_DEPTH   = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } coll_state_t;

    // Leaves room for every in-flight message plus one issued before the counter reacts.
    function automatic int pause_threshold(input int depth, input int latency);
        return depth - latency - 2;
    endfunction

endpackage

// File: rtl/des_hit_collector_if.sv
// Message/cipher streams from the counter and DES core, and the hit pop port to the host.
interface des_hit_collector_if;
    import des_search_pkg::*;

    logic [MSG_W-1:0] msg_in;
    logic             msg_valid;
    logic             gen_done;
    logic             pause;
    logic [MSG_W-1:0] cipher_in;
    logic             cipher_valid;
    logic [MSG_W-1:0] hit_msg;
    logic             hit_valid;
    logic             hit_ready;

    modport master (
        output msg_in, msg_valid, gen_done, cipher_in, cipher_valid, hit_ready,
        input  pause, hit_msg, hit_valid
    );

    modport slave (
        input  msg_in, msg_valid, gen_done, cipher_in, cipher_valid, hit_ready,
        output pause, hit_msg, hit_valid
    );

endinterface

// File: rtl/des_hit_collector_fifo.sv
// First-word-fall-through hit buffer; a push into a full FIFO is accepted only alongside a pop.
module hit_fifo #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // When full, push+pop writes the slot being read this cycle; it becomes the new tail.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/des_hit_collector.sv
// Aligns counter messages with DES ciphertext, buffers masked-target matches, paces the counter.
//  state | meaning
//  IDLE  | waiting for start, no compares
//  RUN   | counter streaming, compare/push active
//  DRAIN | counter finished, flushing delay line
//  DONE  | region searched and drained, hits still readable
module des_hit_collector
    import des_search_pkg::*;
#(
    parameter int LATENCY = DEF_LATENCY,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [MSG_W-1:0]   target,
    input  logic [MSG_W-1:0]   mask,
    des_hit_collector_if.slave bus,
    output logic [CNT_W-1:0]   hit_count,
    output logic               overflow,
    output logic               align_err,
    output logic               region_done
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PAUSE_TH = (AW+1)'(pause_threshold(DEPTH, LATENCY));

    coll_state_t      state;
    coll_state_t      state_nxt;
    logic [MSG_W-1:0] target_q;
    logic [MSG_W-1:0] mask_q;
    logic [MSG_W-1:0] dl_msg [LATENCY];
    logic [LATENCY-1:0] dl_vld;

    logic             active;
    logic             al_vld;
    logic [MSG_W-1:0] al_msg;
    logic             cmp_ok;
    logic             hit;
    logic             misalign;
    logic             drop;

    logic [MSG_W-1:0] fifo_rdata;
    logic [AW:0]      fifo_count;
    logic             fifo_full;
    logic             fifo_empty;

    assign active   = (state == RUN) || (state == DRAIN);
    assign al_vld   = dl_vld[LATENCY-1];
    assign al_msg   = dl_msg[LATENCY-1];
    assign cmp_ok   = ((bus.cipher_in ^ target_q) & mask_q) == '0;
    assign hit      = active & al_vld & bus.cipher_valid & cmp_ok;
    assign misalign = active & (al_vld != bus.cipher_valid);
    assign drop     = hit & fifo_full & ~bus.hit_ready;

    assign bus.pause     = (fifo_count >= PAUSE_TH);
    assign bus.hit_msg   = fifo_rdata;
    assign bus.hit_valid = ~fifo_empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        region_done = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = RUN;
            RUN: begin
                if (start)             state_nxt = RUN;
                else if (bus.gen_done) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (start)              state_nxt = RUN;
                else if (dl_vld == '0)  state_nxt = DONE;
            end
            DONE: begin
                region_done = 1'b1;
                if (start) state_nxt = RUN;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Delay line is never stalled; start discards anything in flight from the old region.
    always_ff @(posedge clk) begin
        if (!rst_n || start) begin
            dl_vld <= '0;
        end else begin
            dl_vld[0] <= bus.msg_valid;
            for (int i = 1; i < LATENCY; i++) dl_vld[i] <= dl_vld[i-1];
        end
    end

    always_ff @(posedge clk) begin
        dl_msg[0] <= bus.msg_in;
        for (int i = 1; i < LATENCY; i++) dl_msg[i] <= dl_msg[i-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            target_q  <= '0;
            mask_q    <= '0;
            hit_count <= '0;
            overflow  <= 1'b0;
            align_err <= 1'b0;
        end else if (start) begin
            target_q  <= target;
            mask_q    <= mask;
            hit_count <= '0;
            overflow  <= 1'b0;
            align_err <= 1'b0;
        end else begin
            if (hit && !(&hit_count)) hit_count <= hit_count + 1'b1;
            if (drop)                 overflow  <= 1'b1;
            if (misalign)             align_err <= 1'b1;
        end
    end

    hit_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (MSG_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start),
        .push  (hit),
        .wdata (al_msg),
        .pop   (bus.hit_ready),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_des_hit_collector.sv
// Directed bench for des_hit_collector with a behavioural DES pipeline stand-in.
module tb_des_hit_collector;
    import des_search_pkg::*;

    localparam int L = 16;
    localparam int D = 32;

    typedef struct {
        logic [63:0] msg;
        logic [63:0] flip;
        logic [63:0] mask;
        logic        exp_hit;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [63:0] target = '0;
    logic [63:0] mask = '0;
    logic [15:0] hit_count;
    logic        overflow;
    logic        align_err;
    logic        region_done;

    logic        cv_force_en = 1'b0;
    logic        cv_force_val = 1'b0;
    logic [63:0] p_msg [L];
    logic [L-1:0] p_vld;

    int vec_cnt = 0;
    int miss_cnt = 0;
    vec_t vecs [8];

    des_hit_collector_if bus ();

    des_hit_collector #(
        .LATENCY (L),
        .DEPTH   (D),
        .CNT_W   (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .target      (target),
        .mask        (mask),
        .bus         (bus),
        .hit_count   (hit_count),
        .overflow    (overflow),
        .align_err   (align_err),
        .region_done (region_done)
    );

    always #5 clk = ~clk;

    // Invertible stand-in for DES: odd multiply then xorshift.
    function automatic logic [63:0] des_model(input logic [63:0] m);
        logic [63:0] x;
        x = m * 64'h9E37_79B9_7F4A_7C15;
        return x ^ (x >> 29) ^ 64'h0123_4567_89AB_CDEF;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) p_vld <= '0;
        else        p_vld <= {p_vld[L-2:0], bus.msg_valid};
        p_msg[0] <= bus.msg_in;
        for (int i = 1; i < L; i++) p_msg[i] <= p_msg[i-1];
    end

    assign bus.cipher_in    = des_model(p_msg[L-1]);
    assign bus.cipher_valid = cv_force_en ? cv_force_val : p_vld[L-1];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_start(input logic [63:0] t, input logic [63:0] m);
        start  = 1'b1;
        target = t;
        mask   = m;
        tick();
        start  = 1'b0;
    endtask

    task automatic send_burst(input int n, input logic [63:0] first);
        for (int i = 0; i < n; i++) begin
            bus.msg_in    = first + 64'(i);
            bus.msg_valid = 1'b1;
            tick();
        end
        bus.msg_valid = 1'b0;
    endtask

    task automatic drain_check(input string nm, input int exp_n, input logic [63:0] first);
        int n;
        n = 0;
        bus.hit_ready = 1'b1;
        for (int k = 0; k < exp_n + 8; k++) begin
            if (bus.hit_valid) begin
                chk(nm, bus.hit_msg, first + 64'(n));
                n++;
            end
            tick();
        end
        bus.hit_ready = 1'b0;
        chk({nm, "_n"}, 64'(n), 64'(exp_n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int sent;
        logic pause_prev;
        logic seen_pause;

        vecs[0] = '{64'h5, 64'h0,                   64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
        vecs[1] = '{64'h5, 64'h1,                   64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
        vecs[2] = '{64'h7, 64'h1,                   64'hFFFF_FFFF_FFFF_FFFE, 1'b1};
        vecs[3] = '{64'h9, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                   1'b1};
        vecs[4] = '{64'hA, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0};
        vecs[5] = '{64'hB, 64'h0000_0000_0000_FF00, 64'h0000_0000_0000_00FF, 1'b1};
        vecs[6] = '{64'hC, 64'h0000_0001_0000_0000, 64'h0000_0000_FFFF_FFFF, 1'b1};
        vecs[7] = '{64'hD, 64'h0000_0001_0000_0000, 64'hFFFF_FFFF_0000_0000, 1'b0};

        bus.msg_in    = '0;
        bus.msg_valid = 1'b0;
        bus.gen_done  = 1'b0;
        bus.hit_ready = 1'b0;

        tick();
        tick();
        chk("rst_pause",     64'(bus.pause),     64'h0);
        chk("rst_hit_valid", 64'(bus.hit_valid), 64'h0);
        chk("rst_hit_count", 64'(hit_count),     64'h0);
        chk("rst_overflow",  64'(overflow),      64'h0);
        chk("rst_align_err", 64'(align_err),     64'h0);
        chk("rst_region",    64'(region_done),   64'h0);
        chk("rst_state",     64'(dut.state),     64'(IDLE));
        rst_n = 1'b1;
        tick();

        // Single-message compare table
        for (int i = 0; i < 8; i++) begin
            do_start(des_model(vecs[i].msg) ^ vecs[i].flip, vecs[i].mask);
            send_burst(1, vecs[i].msg);
            repeat (L + 2) tick();
            chk($sformatf("vec%0d_valid", i), 64'(bus.hit_valid), 64'(vecs[i].exp_hit));
            chk($sformatf("vec%0d_count", i), 64'(hit_count),     64'(vecs[i].exp_hit));
            chk($sformatf("vec%0d_align", i), 64'(align_err),     64'h0);
            if (vecs[i].exp_hit)
                chk($sformatf("vec%0d_msg", i), bus.hit_msg, vecs[i].msg);
        end

        // Exact match over a 32-message region, then drain to DONE
        do_start(des_model(64'h5), 64'hFFFF_FFFF_FFFF_FFFF);
        send_burst(32, 64'h0);
        bus.gen_done = 1'b1;
        k = 0;
        for (int c = 1; c <= 60; c++) begin
            tick();
            k = c;
            if (region_done) break;
        end
        chk("exact_done_lat", 64'(k), 64'(L + 1));
        chk("exact_count",    64'(hit_count), 64'h1);
        chk("exact_msg",      bus.hit_msg, 64'h5);
        chk("exact_state",    64'(dut.state), 64'(DONE));
        bus.gen_done = 1'b0;
        drain_check("exact_pop", 1, 64'h5);
        chk("exact_done_held", 64'(region_done), 64'h1);

        // Counter honouring pause with a one-cycle reaction
        do_start(64'h0, 64'h0);
        sent = 0;
        pause_prev = 1'b0;
        seen_pause = 1'b0;
        for (int c = 0; c < 120; c++) begin
            if (sent < 40 && !pause_prev) begin
                bus.msg_in    = 64'(sent);
                bus.msg_valid = 1'b1;
                sent++;
            end else begin
                bus.msg_valid = 1'b0;
            end
            if (bus.pause && !seen_pause) begin
                seen_pause = 1'b1;
                chk("pause_rise_count", 64'(hit_count), 64'd14);
            end
            pause_prev = bus.pause;
            tick();
        end
        bus.msg_valid = 1'b0;
        chk("pause_seen",     64'(seen_pause), 64'h1);
        chk("pause_sent",     64'(sent),       64'd31);
        chk("pause_count",    64'(hit_count),  64'd31);
        chk("pause_overflow", 64'(overflow),   64'h0);
        drain_check("pause_order", 31, 64'h0);

        // Counter ignoring pause: drops beyond 32 entries
        do_start(64'h0, 64'h0);
        send_burst(40, 64'h0);
        repeat (L + 3) tick();
        chk("ovf_flag",  64'(overflow),  64'h1);
        chk("ovf_count", 64'(hit_count), 64'd40);
        drain_check("ovf_pop", 32, 64'h0);

        // Full FIFO, push and pop in the same cycle
        do_start(64'h0, 64'h0);
        send_burst(32, 64'h0);
        repeat (L + 3) tick();
        chk("full_count0", 64'(hit_count), 64'd32);
        chk("full_ovf0",   64'(overflow),  64'h0);
        send_burst(1, 64'd32);
        repeat (L - 1) tick();
        bus.hit_ready = 1'b1;
        chk("full_pp_head", bus.hit_msg, 64'h0);
        tick();
        bus.hit_ready = 1'b0;
        chk("full_pp_ovf",   64'(overflow),  64'h0);
        chk("full_pp_count", 64'(hit_count), 64'd33);
        drain_check("full_pp_pop", 32, 64'h1);

        // Cipher valid one cycle early
        do_start(64'h0, 64'h0);
        send_burst(1, 64'h7);
        repeat (L - 2) tick();
        chk("early_pre_align", 64'(align_err), 64'h0);
        cv_force_en  = 1'b1;
        cv_force_val = 1'b1;
        tick();
        cv_force_val = 1'b0;
        tick();
        cv_force_en  = 1'b0;
        repeat (3) tick();
        chk("early_align", 64'(align_err),     64'h1);
        chk("early_count", 64'(hit_count),     64'h0);
        chk("early_valid", 64'(bus.hit_valid), 64'h0);

        // Restart mid-DRAIN with hits stored
        do_start(64'h0, 64'h0);
        send_burst(5, 64'h0);
        bus.gen_done = 1'b1;
        repeat (L - 2) tick();
        chk("rs_pre_state", 64'(dut.state),     64'(DRAIN));
        chk("rs_pre_valid", 64'(bus.hit_valid), 64'h1);
        bus.gen_done = 1'b0;
        do_start(64'h0, 64'h0);
        chk("rs_valid",  64'(bus.hit_valid), 64'h0);
        chk("rs_count",  64'(hit_count),     64'h0);
        chk("rs_state",  64'(dut.state),     64'(RUN));
        chk("rs_region", 64'(region_done),   64'h0);
        chk("rs_align",  64'(align_err),     64'h0);

        // Reset mid-RUN
        send_burst(20, 64'h100);
        repeat (L + 2) tick();
        chk("mr_pre_pause", 64'(bus.pause), 64'h1);
        rst_n = 1'b0;
        tick();
        chk("mr_pause",     64'(bus.pause),     64'h0);
        chk("mr_hit_valid", 64'(bus.hit_valid), 64'h0);
        chk("mr_hit_msg",   bus.hit_msg,        64'h0);
        chk("mr_hit_count", 64'(hit_count),     64'h0);
        chk("mr_overflow",  64'(overflow),      64'h0);
        chk("mr_align_err", 64'(align_err),     64'h0);
        chk("mr_region",    64'(region_done),   64'h0);
        chk("mr_state",     64'(dut.state),     64'(IDLE));
        rst_n = 1'b1;
        send_burst(1, 64'h9);
        repeat (L + 3) tick();
        chk("mr_idle_valid", 64'(bus.hit_valid), 64'h0);
        chk("mr_idle_count", 64'(hit_count),     64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
